// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types and constants for branch resolution
// Contents: FSM state encoding, 2-bit BHT counter values, PC increment,
//           and the saturating counter next-value helper.
package core_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REDIR = 2'd1,
    FLUSH = 2'd2
  } br_state_e;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam int PC_INC = 4;

  function automatic logic [1:0] bht_next(input logic [1:0] cnt, input logic taken);
    if (taken) begin
      return (cnt == ST) ? ST : cnt + 2'd1;
    end
    return (cnt == SNT) ? SNT : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// rtl/branch_ctrl_if.sv - pipeline-side bundle of the branch resolution unit
// master: ID/EX/IF side (drives lookup PC, EX resolution, redirect_ready)
// slave : branch_ctrl (drives prediction, redirect request, flushes, counters)
interface branch_ctrl_if #(
  parameter int DATA_WITDH = 32
);
  logic [DATA_WITDH-1:0] id_pc;
  logic                  id_pred_taken;
  logic                  ex_valid;
  logic                  ex_stall;
  logic                  ex_is_br;
  logic                  ex_jalx;
  logic                  ex_taken;
  logic                  ex_pred;
  logic [DATA_WITDH-1:0] ex_pc;
  logic [DATA_WITDH-1:0] ex_target;
  logic                  redirect_ready;
  logic                  redirect_valid;
  logic [DATA_WITDH-1:0] redirect_pc;
  logic                  flush_ifid;
  logic                  flush_idex;
  logic [DATA_WITDH-1:0] br_count;
  logic [DATA_WITDH-1:0] mis_count;

  modport master (
    output id_pc, ex_valid, ex_stall, ex_is_br, ex_jalx, ex_taken, ex_pred,
           ex_pc, ex_target, redirect_ready,
    input  id_pred_taken, redirect_valid, redirect_pc, flush_ifid, flush_idex,
           br_count, mis_count
  );

  modport slave (
    input  id_pc, ex_valid, ex_stall, ex_is_br, ex_jalx, ex_taken, ex_pred,
           ex_pc, ex_target, redirect_ready,
    output id_pred_taken, redirect_valid, redirect_pc, flush_ifid, flush_idex,
           br_count, mis_count
  );
endinterface

// File: rtl/bht_2bit.sv
// rtl/bht_2bit.sv - table of 2-bit saturating direction counters
// Ports: clk, rst_n (sync, active-low, reinitialises to weakly not-taken),
//        rd_idx_i/rd_cnt_o (combinational lookup),
//        upd_en_i/upd_idx_i/upd_taken_i (update on rising edge).
module bht_2bit
  import core_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [1:0]       rd_cnt_o,
  input  logic             upd_en_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i
);

  localparam int ENTRIES = 2 ** IDX_W;

  logic [1:0] cnt_q [ENTRIES];

  // Read is taken from the registered array, so a same-cycle update to the
  // same index is only visible from the next cycle on.
  assign rd_cnt_o = cnt_q[rd_idx_i];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        cnt_q[i] <= WNT;
      end
    end else if (upd_en_i) begin
      cnt_q[upd_idx_i] <= bht_next(cnt_q[upd_idx_i], upd_taken_i);
    end
  end

endmodule

// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - branch resolution, redirect sequencing and BHT owner
// Ports: clk, rst_n (sync, active-low), bus (branch_ctrl_if.slave):
//        ID lookup, EX resolution inputs, redirect valid/ready/pc,
//        IF/ID and ID/EX flushes, branch and mispredict counters.
module branch_ctrl
  import core_pkg::*;
#(
  parameter int DATA_WITDH = 32,
  parameter int BHT_IDX_W  = 4
) (
  input  logic clk,
  input  logic rst_n,
  branch_ctrl_if.slave bus
);

  br_state_e             state_q, state_d;
  logic                  redirect_valid_q, redirect_valid_d;
  logic [DATA_WITDH-1:0] redirect_pc_q, redirect_pc_d;
  logic                  flush_q, flush_d;
  logic [DATA_WITDH-1:0] br_count_q, mis_count_q;

  logic                  resolve;
  logic                  mispredict;
  logic                  go_redir;
  logic                  br_upd;
  logic [DATA_WITDH-1:0] target;
  logic [1:0]            rd_cnt;

  // EX contents outside IDLE are wrong-path and never consumed.
  assign resolve    = bus.ex_valid & ~bus.ex_stall & (state_q == IDLE);
  assign mispredict = bus.ex_jalx | (bus.ex_is_br & (bus.ex_taken != bus.ex_pred));
  assign go_redir   = resolve & mispredict;
  // A jump wins over an (illegal) simultaneous branch flag.
  assign br_upd     = resolve & bus.ex_is_br & ~bus.ex_jalx;
  assign target     = (bus.ex_jalx | (bus.ex_is_br & bus.ex_taken))
                      ? bus.ex_target : bus.ex_pc + DATA_WITDH'(PC_INC);

  bht_2bit #(.IDX_W(BHT_IDX_W)) u_bht (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_idx_i    (bus.id_pc[BHT_IDX_W+1:2]),
    .rd_cnt_o    (rd_cnt),
    .upd_en_i    (br_upd),
    .upd_idx_i   (bus.ex_pc[BHT_IDX_W+1:2]),
    .upd_taken_i (bus.ex_taken)
  );

  always_comb begin
    state_d          = state_q;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    flush_d          = flush_q;
    case (state_q)
      IDLE: begin
        if (go_redir) begin
          state_d          = REDIR;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = target;
          flush_d          = 1'b1;
        end
      end
      REDIR: begin
        if (bus.redirect_ready) begin
          state_d          = FLUSH;
          redirect_valid_d = 1'b0;
        end
      end
      // One extra flush cycle kills the fetch issued during the handshake.
      FLUSH: begin
        state_d = IDLE;
        flush_d = 1'b0;
      end
      default: begin
        state_d          = IDLE;
        redirect_valid_d = 1'b0;
        flush_d          = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
      br_count_q       <= '0;
      mis_count_q      <= '0;
    end else begin
      state_q          <= state_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
      if (br_upd) begin
        br_count_q <= br_count_q + 1'b1;
      end
      if (go_redir) begin
        mis_count_q <= mis_count_q + 1'b1;
      end
    end
  end

  assign bus.id_pred_taken  = rd_cnt[1];
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.flush_ifid     = flush_q;
  assign bus.flush_idex     = flush_q;
  assign bus.br_count       = br_count_q;
  assign bus.mis_count      = mis_count_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// tb/tb_branch_ctrl.sv - directed self-checking bench for branch_ctrl
module tb_branch_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  branch_ctrl_if #(.DATA_WITDH(32)) bus ();

  branch_ctrl #(.DATA_WITDH(32), .BHT_IDX_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic rv, input logic [31:0] pc,
                         input logic fl, input logic [31:0] br, input logic [31:0] mis);
    chk({tag, ".rv"},   {31'd0, bus.redirect_valid}, {31'd0, rv});
    chk({tag, ".pc"},   bus.redirect_pc, pc);
    chk({tag, ".fid"},  {31'd0, bus.flush_ifid}, {31'd0, fl});
    chk({tag, ".fex"},  {31'd0, bus.flush_idex}, {31'd0, fl});
    chk({tag, ".br"},   bus.br_count, br);
    chk({tag, ".mis"},  bus.mis_count, mis);
  endtask

  task automatic pred(input string tag, input logic [31:0] pc, input logic exp);
    bus.id_pc = pc;
    #1;
    chk(tag, {31'd0, bus.id_pred_taken}, {31'd0, exp});
  endtask

  task automatic drive_br(input logic [31:0] pc, input logic [31:0] tgt,
                          input logic tk, input logic pr);
    bus.ex_valid  = 1'b1;
    bus.ex_is_br  = 1'b1;
    bus.ex_jalx   = 1'b0;
    bus.ex_pc     = pc;
    bus.ex_target = tgt;
    bus.ex_taken  = tk;
    bus.ex_pred   = pr;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    bus.id_pc = '0; bus.ex_valid = 0; bus.ex_stall = 0; bus.ex_is_br = 0;
    bus.ex_jalx = 0; bus.ex_taken = 0; bus.ex_pred = 0; bus.ex_pc = '0;
    bus.ex_target = '0; bus.redirect_ready = 0;
    repeat (2) step();
    rst_n = 1'b1;

    // 1: reset state and lookup
    pred("t1.pred", 32'h10, 1'b0);
    chk_out("t1", 1'b0, 32'h0, 1'b0, 0, 0);

    // 2: taken branch predicted not-taken, ready already high
    bus.redirect_ready = 1'b1;
    drive_br(32'h100, 32'h80, 1'b1, 1'b0);
    step();
    bus.ex_valid = 1'b0;
    chk_out("t2.redir", 1'b1, 32'h80, 1'b1, 1, 1);
    step();
    chk_out("t2.flush", 1'b0, 32'h80, 1'b1, 1, 1);
    step();
    chk_out("t2.idle", 1'b0, 32'h80, 1'b0, 1, 1);
    pred("t2.pred", 32'h100, 1'b1);

    // 3: backpressure for 3 cycles, wrong-path branch ignored
    bus.redirect_ready = 1'b0;
    drive_br(32'h100, 32'h80, 1'b1, 1'b0);
    step();
    drive_br(32'h104, 32'h300, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk_out($sformatf("t3.hold%0d", i), 1'b1, 32'h80, 1'b1, 2, 2);
      step();
    end
    bus.redirect_ready = 1'b1;
    chk_out("t3.hold3", 1'b1, 32'h80, 1'b1, 2, 2);
    step();
    chk_out("t3.flush", 1'b0, 32'h80, 1'b1, 2, 2);
    step();
    bus.ex_valid = 1'b0;
    chk_out("t3.idle", 1'b0, 32'h80, 1'b0, 2, 2);
    pred("t3.pred104", 32'h104, 1'b0);
    pred("t3.pred100", 32'h100, 1'b1);

    // 4: predicted taken, resolves not-taken, fall-through wraps
    drive_br(32'hFFFF_FFFC, 32'h1234, 1'b0, 1'b1);
    step();
    bus.ex_valid = 1'b0;
    chk_out("t4.redir", 1'b1, 32'h0, 1'b1, 3, 3);
    repeat (2) step();
    chk_out("t4.idle", 1'b0, 32'h0, 1'b0, 3, 3);
    pred("t4.pred", 32'h3C, 1'b0);

    // 5a: saturation at index 2 with correct predictions (no redirect)
    drive_br(32'h108, 32'h700, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("t5.sat_rv%0d", i), {31'd0, bus.redirect_valid}, 32'd0);
    end
    bus.ex_taken = 1'b0;
    bus.ex_pred  = 1'b0;
    step();
    pred("t5.sat_dec1", 32'h108, 1'b1);
    step();
    bus.ex_valid = 1'b0;
    pred("t5.sat_dec2", 32'h108, 1'b0);
    chk_out("t5.cnt", 1'b0, 32'h0, 1'b0, 10, 3);

    // 5b: lookup sees pre-update value in the update cycle
    drive_br(32'h108, 32'h700, 1'b1, 1'b1);
    pred("t5.pre", 32'h108, 1'b0);
    step();
    bus.ex_valid = 1'b0;
    pred("t5.post", 32'h108, 1'b1);

    // 5c: stalled mispredicting branch resolves only after release
    drive_br(32'h10C, 32'h200, 1'b1, 1'b0);
    bus.ex_stall = 1'b1;
    repeat (2) begin
      step();
      chk_out("t5.stall", 1'b0, 32'h0, 1'b0, 11, 3);
      pred("t5.stall_pred", 32'h10C, 1'b0);
    end
    bus.ex_stall = 1'b0;
    step();
    bus.ex_valid = 1'b0;
    chk_out("t5.unstall", 1'b1, 32'h200, 1'b1, 12, 4);
    repeat (2) step();
    pred("t5.unstall_pred", 32'h10C, 1'b1);

    // 5d: jump redirects, no BHT update, br_count unchanged
    bus.ex_valid = 1'b1; bus.ex_is_br = 1'b0; bus.ex_jalx = 1'b1;
    bus.ex_pc = 32'h110; bus.ex_target = 32'h400;
    bus.ex_taken = 1'b1; bus.ex_pred = 1'b0;
    step();
    bus.ex_valid = 1'b0; bus.ex_jalx = 1'b0;
    chk_out("t5.jal", 1'b1, 32'h400, 1'b1, 12, 5);
    repeat (2) step();
    chk_out("t5.jal_idle", 1'b0, 32'h400, 1'b0, 12, 5);
    pred("t5.jal_pred", 32'h110, 1'b0);

    // 6: reset while REDIR is waiting on ready
    bus.redirect_ready = 1'b0;
    drive_br(32'h114, 32'h500, 1'b1, 1'b0);
    step();
    bus.ex_valid = 1'b0;
    chk_out("t6.redir", 1'b1, 32'h500, 1'b1, 13, 6);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk_out("t6.rst", 1'b0, 32'h0, 1'b0, 0, 0);
    bus.redirect_ready = 1'b1;
    step();
    chk_out("t6.after", 1'b0, 32'h0, 1'b0, 0, 0);
    pred("t6.bht", 32'h100, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
